// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/writeback-to-decode and decode-to-execute signal bundle
interface decode_stage_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FlushE;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic        StallD;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic        ValidE;
    logic        IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    modport master (
        output InstrD, PCD, PCPlus4D, ValidD, FlushE, RD1D, RD2D,
               RegWriteW, RdW, ResultW,
        input  A1, A2, StallD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE,
               ALUSrcE, ValidE, IllegalE, ResultSrcE, ALUControlE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, ValidD, FlushE, RD1D, RD2D,
               RegWriteW, RdW, ResultW,
        output A1, A2, StallD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE,
               ALUSrcE, ValidE, IllegalE, ResultSrcE, ALUControlE
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode with WB bypass, load-use stall and ID/EX register
module decode_stage (
    input  logic         clk,
    input  logic         rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;

    logic        w_reg_write;
    logic        w_mem_write;
    logic        w_jump;
    logic        w_branch;
    logic        w_alu_src;
    logic        w_illegal;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [1:0]  w_result_src;
    logic [2:0]  w_alu_ctrl;
    logic [31:0] w_imm;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_hazard;
    logic        w_bubble;

    logic [31:0] r_rd1, r_rd2, r_imm, r_pc, r_pc_plus4;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic        r_reg_write, r_mem_write, r_jump, r_branch, r_alu_src, r_valid, r_illegal;
    logic [1:0]  r_result_src;
    logic [2:0]  r_alu_ctrl;

    assign w_instr  = bus.InstrD;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_illegal    = 1'b0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_result_src = 2'b00;
        w_alu_ctrl   = 3'b000;
        w_imm        = 32'd0;
        case (w_opcode)
            OP_R, OP_I: begin
                w_reg_write = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = (w_opcode == OP_R);
                w_alu_src   = (w_opcode == OP_I);
                if (w_opcode == OP_I)
                    w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
                case (w_funct3)
                    3'b000:  w_alu_ctrl = ((w_opcode == OP_R) && w_instr[30]) ? 3'b001 : 3'b000;
                    3'b110:  w_alu_ctrl = 3'b011;
                    3'b111:  w_alu_ctrl = 3'b010;
                    3'b010:  w_alu_ctrl = 3'b101;
                    default: w_illegal  = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
                w_use_rs1    = 1'b1;
                w_imm        = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_imm       = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            OP_BRANCH: begin
                w_branch   = 1'b1;
                w_alu_ctrl = 3'b001;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_imm      = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                w_reg_write  = 1'b1;
                w_jump       = 1'b1;
                w_result_src = 2'b10;
                w_imm        = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // The register file writes on the edge, so a same-cycle writeback must be forwarded here.
    always_comb begin
        w_rd1 = bus.RD1D;
        w_rd2 = bus.RD2D;
        if (w_rs1 == 5'd0)
            w_rd1 = 32'd0;
        else if (bus.RegWriteW && (bus.RdW == w_rs1))
            w_rd1 = bus.ResultW;
        if (w_rs2 == 5'd0)
            w_rd2 = 32'd0;
        else if (bus.RegWriteW && (bus.RdW == w_rs2))
            w_rd2 = bus.ResultW;
    end

    assign w_hazard = bus.ValidD && r_valid && (r_result_src == 2'b01) && (r_rd != 5'd0) &&
                      ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));
    assign w_bubble = bus.FlushE || w_hazard || !bus.ValidD;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd1 <= '0; r_rd2 <= '0; r_imm <= '0; r_pc <= '0; r_pc_plus4 <= '0;
            r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0;
            r_reg_write <= 1'b0; r_mem_write <= 1'b0; r_jump <= 1'b0; r_branch <= 1'b0;
            r_alu_src <= 1'b0; r_valid <= 1'b0; r_illegal <= 1'b0;
            r_result_src <= 2'b00; r_alu_ctrl <= 3'b000;
        end else begin
            r_rd1      <= w_rd1;
            r_rd2      <= w_rd2;
            r_imm      <= w_imm;
            r_pc       <= bus.PCD;
            r_pc_plus4 <= bus.PCPlus4D;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            if (w_bubble) begin
                r_reg_write <= 1'b0; r_mem_write <= 1'b0; r_jump <= 1'b0; r_branch <= 1'b0;
                r_alu_src <= 1'b0; r_valid <= 1'b0; r_illegal <= 1'b0;
                r_result_src <= 2'b00; r_alu_ctrl <= 3'b000;
            end else begin
                r_reg_write  <= w_reg_write;
                r_mem_write  <= w_mem_write;
                r_jump       <= w_jump;
                r_branch     <= w_branch;
                r_alu_src    <= w_alu_src;
                r_valid      <= 1'b1;
                r_illegal    <= w_illegal;
                r_result_src <= w_result_src;
                r_alu_ctrl   <= w_alu_ctrl;
            end
        end
    end

    assign bus.A1          = w_rs1;
    assign bus.A2          = w_rs2;
    assign bus.StallD      = w_hazard;
    assign bus.RD1E        = r_rd1;
    assign bus.RD2E        = r_rd2;
    assign bus.ImmExtE     = r_imm;
    assign bus.PCE         = r_pc;
    assign bus.PCPlus4E    = r_pc_plus4;
    assign bus.Rs1E        = r_rs1;
    assign bus.Rs2E        = r_rs2;
    assign bus.RdE         = r_rd;
    assign bus.RegWriteE   = r_reg_write;
    assign bus.MemWriteE   = r_mem_write;
    assign bus.JumpE       = r_jump;
    assign bus.BranchE     = r_branch;
    assign bus.ALUSrcE     = r_alu_src;
    assign bus.ValidE      = r_valid;
    assign bus.IllegalE    = r_illegal;
    assign bus.ResultSrcE  = r_result_src;
    assign bus.ALUControlE = r_alu_ctrl;
endmodule
